imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream into 32-bit words and writes them to IMEM.
// Latency: the 4th byte of a word accepted in cycle T gives im_we in T+1; done rises two cycles after the final accepted byte.
// Backpressure: rx_ready is high only while a byte is expected (LEN_HI, LEN_LO, DATA, CSUM); bytes move on rx_valid & rx_ready.
//
// Ports:
//   sysclk, cpu_reset            clock, synchronous active-high reset
//   start                        pulse that opens a load session from IDLE, DONE or ERR
//   rx_valid, rx_data, rx_ready  byte stream from the host link
//   im_we, im_addr, im_wdata     instruction-memory write port, one strobe per word
//   cpu_hold                     keeps the processor in reset while a load is in progress
//   done, err                    sticky session outcome
//   word_count                   words written in the current session
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append a mod-256 checksum byte
// to the stream, verified before the load is declared done.
module imem_loader #(
   parameter int ADDR_W        = 8,
   parameter bit HOLD_AT_RESET = 1'b1
) (
   input  logic              sysclk,
   input  logic              cpu_reset,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM   = 3'd4,
`endif
      S_FLUSH  = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   // Where the stream goes once all data words (possibly zero) are in.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t POST_DATA = S_CSUM;
`else
   localparam state_t POST_DATA = S_FLUSH;
`endif

   localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

   state_t      state;
   logic [15:0] len;
   logic [1:0]  byte_idx;
   logic [23:0] asm_r;      // first three bytes of the word being assembled
   logic        acc;
   logic [15:0] len_rx;     // full word count as it completes in LEN_LO
   logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   always_comb begin
      rx_ready = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO, S_DATA: rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM:                     rx_ready = 1'b1;
`endif
         default:                    rx_ready = 1'b0;
      endcase
   end

   assign acc       = rx_valid & rx_ready;
   assign len_rx    = {len[15:8], rx_data};
   // word_count is the index of the word being completed; +1 gives words written after it.
   assign last_word = (32'(word_count) + 32'd1) == 32'(len);

   always_ff @(posedge sysclk) begin
      if (cpu_reset) begin
         state      <= S_IDLE;
         im_we      <= 1'b0;
         im_addr    <= '0;
         im_wdata   <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
         cpu_hold   <= HOLD_AT_RESET;
         len        <= '0;
         byte_idx   <= '0;
         asm_r      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         im_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state      <= S_LEN_HI;
                  word_count <= '0;
                  byte_idx   <= '0;
                  len        <= '0;
                  cpu_hold   <= 1'b1;
                  done       <= 1'b0;
                  err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum       <= '0;
`endif
               end
            end
            S_LEN_HI: begin
               if (acc) begin
                  len[15:8] <= rx_data;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (acc) begin
                  len[7:0] <= rx_data;
                  // Rejecting oversize loads here is what keeps im_addr from wrapping.
                  if (32'(len_rx) > MAX_WORDS) begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end else if (len_rx == 16'd0) begin
                     state <= POST_DATA;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (acc) begin
                  asm_r    <= {asm_r[15:0], rx_data};
                  byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= csum + rx_data;
`endif
                  if (byte_idx == 2'd3) begin
                     im_we      <= 1'b1;
                     im_addr    <= word_count[ADDR_W-1:0];
                     im_wdata   <= {asm_r, rx_data};
                     word_count <= word_count + 1'b1;
                     if (last_word) state <= POST_DATA;
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (acc) begin
                  if (rx_data == csum) begin
                     state <= S_FLUSH;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            S_FLUSH: begin
               state    <= S_DONE;
               done     <= 1'b1;
               cpu_hold <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
   localparam int ADDR_W = 8;
   localparam int MAXW   = 1 << ADDR_W;

   logic              sysclk = 1'b0;
   logic              cpu_reset = 1'b1;
   logic              start = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   word_count;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   logic [31:0]       sent_words[$];

   typedef struct {
      int n;
      bit gaps;
      bit bad_csum;
      bit exp_done;
      bit exp_err;
      int exp_wc;
   } vec_t;
   vec_t vecs[$];

   always #5 sysclk = ~sysclk;

   imem_loader #(.ADDR_W(ADDR_W), .HOLD_AT_RESET(1'b1)) dut (
      .sysclk(sysclk), .cpu_reset(cpu_reset), .start(start),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
   );

   // Record every write strobe, sampled mid-cycle.
   always @(negedge sysclk) begin
      if (im_we === 1'b1) begin
         wr_addr.push_back(im_addr);
         wr_data.push_back(im_wdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int guard = 0;
      if (gaps) begin
         while ($urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            tick();
         end
      end
      rx_valid = 1'b1;
      rx_data  = b;
      while (rx_ready !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      check("rx_accept_wait", rx_ready, 1);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_end();
      int guard = 0;
      while (done !== 1'b1 && err !== 1'b1 && guard < 10) begin
         tick();
         guard++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"},   rx_ready, 0);
      check({tag, "_im_we"},      im_we, 0);
      check({tag, "_im_addr"},    im_addr, 0);
      check({tag, "_im_wdata"},   im_wdata, 0);
      check({tag, "_done"},       done, 0);
      check({tag, "_err"},        err, 0);
      check({tag, "_word_count"}, word_count, 0);
      check({tag, "_cpu_hold"},   cpu_hold, 1);
   endtask

   // Full session with random words; the model is simply the list of words sent.
   task automatic run_session(input int n, input bit gaps, input bit bad_csum);
      logic [7:0]  sum;
      logic [7:0]  csum_byte;
      logic [31:0] w;
      sum = 8'd0;
      sent_words.delete();
      wr_addr.delete();
      wr_data.delete();
      do_start();
      send_byte(8'(n >> 8), gaps);
      send_byte(8'(n), gaps);
      if (n > MAXW) begin
         wait_end();
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         sent_words.push_back(w);
         for (int b = 3; b >= 0; b--) begin
            send_byte(w[8*b +: 8], gaps);
            sum = sum + w[8*b +: 8];
         end
      end
      csum_byte = bad_csum ? sum + 8'd1 : sum;
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(csum_byte, gaps);
`endif
      wait_end();
   endtask

   task automatic check_session(input string tag, input bit exp_done, input bit exp_err, input int exp_wc);
      int bad = 0;
      int m;
      check({tag, "_done"},       done, exp_done);
      check({tag, "_err"},        err, exp_err);
      check({tag, "_cpu_hold"},   cpu_hold, !exp_done);
      check({tag, "_word_count"}, word_count, exp_wc);
      check({tag, "_n_writes"},   wr_addr.size(), exp_wc);
      m = (wr_addr.size() < sent_words.size()) ? wr_addr.size() : sent_words.size();
      for (int i = 0; i < m; i++) begin
         if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== sent_words[i]) bad++;
      end
      check({tag, "_write_order"}, bad, 0);
   endtask

   initial begin
      vecs.push_back('{n: 0,     gaps: 0, bad_csum: 0, exp_done: 1, exp_err: 0, exp_wc: 0});
      vecs.push_back('{n: 1,     gaps: 1, bad_csum: 0, exp_done: 1, exp_err: 0, exp_wc: 1});
      vecs.push_back('{n: 3,     gaps: 1, bad_csum: 0, exp_done: 1, exp_err: 0, exp_wc: 3});
      vecs.push_back('{n: 257,   gaps: 0, bad_csum: 0, exp_done: 0, exp_err: 1, exp_wc: 0});
      vecs.push_back('{n: 5,     gaps: 1, bad_csum: 0, exp_done: 1, exp_err: 0, exp_wc: 5});
      vecs.push_back('{n: 65535, gaps: 1, bad_csum: 0, exp_done: 0, exp_err: 1, exp_wc: 0});
      vecs.push_back('{n: 256,   gaps: 0, bad_csum: 0, exp_done: 1, exp_err: 0, exp_wc: 256});
`ifdef IMEM_LOADER_CHECKSUM_EN
      vecs.push_back('{n: 2,     gaps: 1, bad_csum: 1, exp_done: 0, exp_err: 1, exp_wc: 2});
      vecs.push_back('{n: 4,     gaps: 1, bad_csum: 0, exp_done: 1, exp_err: 0, exp_wc: 4});
`endif

      // Reset state
      cpu_reset = 1'b1;
      tick();
      tick();
      check_reset_outputs("reset");
      cpu_reset = 1'b0;
      tick();
      check("idle_hold", cpu_hold, 1);

      // Single word with exact timing around the last byte
      wr_addr.delete();
      wr_data.delete();
      do_start();
      check("len_hi_ready", rx_ready, 1);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h56, 0);
      send_byte(8'h78, 0);
      check("w1_im_we",      im_we, 1);
      check("w1_im_addr",    im_addr, 0);
      check("w1_im_wdata",   im_wdata, 32'h12345678);
      check("w1_word_count", word_count, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h14, 0);
`endif
      check("w1_not_done_yet", done, 0);
      tick();
      check("w1_im_we_single", im_we, 0);
      check("w1_done",         done, 1);
      check("w1_cpu_hold",     cpu_hold, 0);
      check("w1_rx_ready",     rx_ready, 0);
      check("w1_n_writes",     wr_addr.size(), 1);

      // Empty program
      wr_addr.delete();
      wr_data.delete();
      do_start();
      check("n0_done_cleared", done, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h00, 0);
`endif
      check("n0_not_done_yet", done, 0);
      tick();
      check("n0_done",       done, 1);
      check("n0_word_count", word_count, 0);
      check("n0_n_writes",   wr_addr.size(), 0);

      // Oversize length: error right after LEN_LO
      wr_addr.delete();
      wr_data.delete();
      do_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      check("n257_err",      err, 1);
      check("n257_rx_ready", rx_ready, 0);
      check("n257_cpu_hold", cpu_hold, 1);
      tick();
      tick();
      check("n257_err_sticky", err, 1);
      check("n257_n_writes",   wr_addr.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum good and bad
      do_start();
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
      send_byte(8'h0A, 0);
      wait_end();
      check("csum_good_done", done, 1);
      check("csum_good_err",  err, 0);
      do_start();
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
      send_byte(8'h0B, 0);
      wait_end();
      check("csum_bad_err",      err, 1);
      check("csum_bad_done",     done, 0);
      check("csum_bad_cpu_hold", cpu_hold, 1);
`endif

      // Table of randomised sessions
      foreach (vecs[k]) begin
         run_session(vecs[k].n, vecs[k].gaps, vecs[k].bad_csum);
         check_session($sformatf("vec%0d_n%0d", k, vecs[k].n),
                       vecs[k].exp_done, vecs[k].exp_err, vecs[k].exp_wc);
      end

      // Reset in the middle of a session, then a clean reload
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
      cpu_reset = 1'b1;
      tick();
      check_reset_outputs("midreset");
      cpu_reset = 1'b0;
      tick();
      check("midreset_idle_done", done, 0);
      run_session(2, 1, 0);
      check_session("after_reset", 1, 0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
